// File: rtl/page_table_walker_pkg.sv
// Shared Sv32 walker types: PTE layout, Tlb entry, walker states.
// Ports: none (package only).
package page_table_walker_pkg;

    localparam int PTE_SIZE_LOG2 = 2;
    localparam int LEVELS        = 2;

    typedef logic [19:0] virtual_page_number_t;
    typedef logic [21:0] physical_page_number_t;
    typedef logic [33:0] paddr_t;

    typedef enum logic [1:0] {
        Instruction = 2'd0,
        Load        = 2'd1,
        Store       = 2'd2
    } MemoryAccessType;

    typedef struct packed {
        logic                  mode;
        logic [8:0]            asid;
        physical_page_number_t ppn;
    } csr_satp_t;

    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } sv32_pte_t;

    // flags holds PTE bits [7:0] (D A G U X W R V)
    typedef struct packed {
        logic                  valid;
        logic                  fault;
        logic [7:0]            flags;
        physical_page_number_t pageNumber;
    } TlbEntry;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1_REQ,
        S_L1_WAIT,
        S_L0_REQ,
        S_L0_WAIT,
        S_FILL
`ifdef PTW_HW_AD_UPDATE_EN
        ,
        S_AD_REQ,
        S_AD_WAIT
`endif
    } PtwState;

    function automatic paddr_t pteAddr(
        input physical_page_number_t ppn,
        input logic [9:0]            idx
    );
        return {ppn, idx, {PTE_SIZE_LOG2{1'b0}}};
    endfunction

endpackage

// File: rtl/page_table_walker_if.sv
// Single-outstanding PTE memory port between walker and arbiter.
// master: walker (req/write/addr/wdata out); slave: memory side.
interface page_table_walker_if;
    import page_table_walker_pkg::*;

    logic        memReq;
    logic        memWrite;
    paddr_t      memAddr;
    logic [31:0] memWriteValue;
    logic        memGrant;
    logic        memRespValid;
    logic [31:0] memReadValue;

    modport master (
        output memReq, memWrite, memAddr, memWriteValue,
        input  memGrant, memRespValid, memReadValue
    );

    modport slave (
        input  memReq, memWrite, memAddr, memWriteValue,
        output memGrant, memRespValid, memReadValue
    );

endinterface

// File: rtl/page_table_walker_pte_checker.sv
// Combinational Sv32 PTE classifier for one walk level.
// Ports: pte_i, level1_i, accessType_i -> fault_o, isLeaf_o, needAd_o.
module pte_checker
    import page_table_walker_pkg::*;
(
    input  sv32_pte_t       pte_i,
    input  logic            level1_i,
    input  MemoryAccessType accessType_i,
    output logic            fault_o,
    output logic            isLeaf_o,
    output logic            needAd_o
);

    logic misaligned;
    logic unusedBits;

    // permission bits are left to the Tlb
    assign unusedBits = ^{pte_i.ppn1, pte_i.rsw, pte_i.g, pte_i.u};

    assign isLeaf_o   = pte_i.r | pte_i.x;
    assign misaligned = level1_i && isLeaf_o && (pte_i.ppn0 != '0);

    assign fault_o = !pte_i.v
                  || (!pte_i.r && pte_i.w)
                  || (!isLeaf_o && !level1_i)
                  || misaligned;

    assign needAd_o = !pte_i.a
                   || ((accessType_i == Store) && !pte_i.d);

endmodule

// File: rtl/page_table_walker.sv
// Sv32 hardware page-table walker: one Tlb refill per request.
// Ports: clk, rstN; requestEnable/Key/AccessType; busy, done;
//   tlbWriteEnable/Key/Value; mem (page_table_walker_if.master);
//   csrSatp; invalidate. Build option PTW_HW_AD_UPDATE_EN adds
//   A/D write-back; without it a needed A/D update is a fault.
module page_table_walker
    import page_table_walker_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 requestEnable,
    input  virtual_page_number_t requestKey,
    input  logic [1:0]           requestAccessType,
    output logic                 busy,
    output logic                 done,
    output logic                 tlbWriteEnable,
    output virtual_page_number_t tlbWriteKey,
    output TlbEntry              tlbWriteValue,
    page_table_walker_if.master  mem,
    input  logic [31:0]          csrSatp,
    input  logic                 invalidate
);

    localparam int unsigned TW =
        (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);

    PtwState              state_q, state_d;
    virtual_page_number_t key_q, key_d;
    MemoryAccessType      acc_q, acc_d;
    sv32_pte_t            pte_q, pte_d;
    paddr_t               addr_q, addr_d;
    logic                 super_q, super_d;
    logic                 fault_q, fault_d;
    logic                 drop_q, drop_d;
    logic [TW-1:0]        timer_q, timer_d;

    csr_satp_t satp;
    sv32_pte_t rdPte;
    logic      chkFault, chkLeaf, chkNeedAd;
    logic      timeoutHit, dropNow;
    logic      memReqC, memWriteC;
    logic      unusedBits;

    assign satp       = csr_satp_t'(csrSatp);
    assign rdPte      = sv32_pte_t'(mem.memReadValue);
    assign unusedBits = ^{satp.mode, satp.asid, pte_q.rsw};

    pte_checker u_chk (
        .pte_i        (rdPte),
        .level1_i     (state_q == S_L1_WAIT),
        .accessType_i (acc_q),
        .fault_o      (chkFault),
        .isLeaf_o     (chkLeaf),
        .needAd_o     (chkNeedAd)
    );

    // timer restarts on every state change, so it measures the
    // time spent in the current REQ/WAIT state only
    assign timeoutHit = (TimeoutCycles != 0)
                     && (32'(timer_q) >= TimeoutCycles - 1);
    assign dropNow    = drop_q | invalidate;

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        acc_d     = acc_q;
        pte_d     = pte_q;
        addr_d    = addr_q;
        super_d   = super_q;
        fault_d   = fault_q;
        drop_d    = (state_q == S_IDLE) ? 1'b0 : dropNow;
        memReqC   = 1'b0;
        memWriteC = 1'b0;
        done      = 1'b0;
        tlbWriteEnable = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (requestEnable) begin
                    key_d   = requestKey;
                    acc_d   = MemoryAccessType'(requestAccessType);
                    addr_d  = pteAddr(satp.ppn, requestKey[19:10]);
                    super_d = 1'b0;
                    fault_d = 1'b0;
                    state_d = S_L1_REQ;
                end
            end

            S_L1_REQ, S_L0_REQ: begin
                memReqC = 1'b1;
                if (mem.memGrant) begin
                    state_d = (state_q == S_L1_REQ) ? S_L1_WAIT
                                                    : S_L0_WAIT;
                end else if (timeoutHit) begin
                    fault_d = 1'b1;
                    state_d = S_FILL;
                end
            end

            S_L1_WAIT, S_L0_WAIT: begin
                if (mem.memRespValid) begin
                    pte_d = rdPte;
                    if (chkFault) begin
                        fault_d = 1'b1;
                        state_d = S_FILL;
                    end else if (!chkLeaf) begin
                        // checker faults non-leaf at level 0
                        addr_d  = pteAddr({rdPte.ppn1, rdPte.ppn0},
                                          key_q[9:0]);
                        state_d = S_L0_REQ;
                    end else begin
                        super_d = (state_q == S_L1_WAIT);
                        state_d = S_FILL;
                        if (chkNeedAd) begin
`ifdef PTW_HW_AD_UPDATE_EN
                            // dropped walks skip the write-back
                            if (!dropNow) begin
                                pte_d.a = 1'b1;
                                pte_d.d = rdPte.d | (acc_q == Store);
                                state_d = S_AD_REQ;
                            end
`else
                            fault_d = 1'b1;
`endif
                        end
                    end
                end else if (timeoutHit) begin
                    fault_d = 1'b1;
                    state_d = S_FILL;
                end
            end

`ifdef PTW_HW_AD_UPDATE_EN
            S_AD_REQ: begin
                memReqC   = 1'b1;
                memWriteC = 1'b1;
                if (mem.memGrant) begin
                    state_d = S_AD_WAIT;
                end else if (timeoutHit) begin
                    fault_d = 1'b1;
                    state_d = S_FILL;
                end
            end

            S_AD_WAIT: begin
                if (mem.memRespValid) begin
                    state_d = S_FILL;
                end else if (timeoutHit) begin
                    fault_d = 1'b1;
                    state_d = S_FILL;
                end
            end
`endif

            S_FILL: begin
                done           = 1'b1;
                tlbWriteEnable = !dropNow;
                state_d        = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            acc_q   <= Instruction;
            pte_q   <= '0;
            addr_q  <= '0;
            super_q <= 1'b0;
            fault_q <= 1'b0;
            drop_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            acc_q   <= acc_d;
            pte_q   <= pte_d;
            addr_q  <= addr_d;
            super_q <= super_d;
            fault_q <= fault_d;
            drop_q  <= drop_d;
            timer_q <= timer_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign tlbWriteKey = key_q;

    assign mem.memReq   = memReqC;
    assign mem.memWrite = memWriteC;
    assign mem.memAddr  = addr_q;
`ifdef PTW_HW_AD_UPDATE_EN
    assign mem.memWriteValue = pte_q;
`else
    assign mem.memWriteValue = '0;
`endif

    // faulting entries carry no translation and no flags
    always_comb begin
        tlbWriteValue = '0;
        if (state_q == S_FILL) begin
            tlbWriteValue.valid = 1'b1;
            tlbWriteValue.fault = fault_q;
            if (!fault_q) begin
                tlbWriteValue.flags = pte_q[7:0];
                tlbWriteValue.pageNumber = super_q
                    ? {pte_q.ppn1, key_q[9:0]}
                    : {pte_q.ppn1, pte_q.ppn0};
            end
        end
    end

endmodule

// File: tb/tb_page_table_walker.sv
// Self-checking bench for page_table_walker: memory model plus
// scoreboards for PTE accesses and Tlb fills.
module tb_page_table_walker;
    import page_table_walker_pkg::*;

    localparam int unsigned TO       = 8;
    localparam logic [21:0] ROOT     = 22'h080000;
    localparam logic [1:0]  AT_LOAD  = 2'd1;
    localparam logic [1:0]  AT_STORE = 2'd2;

    typedef struct packed {
        logic        we;
        logic [19:0] key;
        TlbEntry     val;
    } fill_t;

    typedef struct packed {
        logic        wr;
        paddr_t      addr;
        logic [31:0] data;
    } acc_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        requestEnable;
    logic [19:0] requestKey;
    logic [1:0]  requestAccessType;
    logic        busy, done, tlbWriteEnable;
    logic [19:0] tlbWriteKey;
    TlbEntry     tlbWriteValue;
    logic [31:0] csrSatp;
    logic        invalidate;

    int nChecks   = 0;
    int nFails    = 0;
    int reqCycles = 0;
    int lat;
    logic [19:0] k;

    fill_t       fillQ[$];
    acc_t        accQ[$];
    logic [31:0] memArr [paddr_t];
    logic        grantEn, lateResp, acc_q;
    logic [31:0] rdData;

    always #5 clk = ~clk;

    page_table_walker_if memIf ();

    page_table_walker #(.TimeoutCycles(TO)) dut (
        .clk               (clk),
        .rstN              (rstN),
        .requestEnable     (requestEnable),
        .requestKey        (requestKey),
        .requestAccessType (requestAccessType),
        .busy              (busy),
        .done              (done),
        .tlbWriteEnable    (tlbWriteEnable),
        .tlbWriteKey       (tlbWriteKey),
        .tlbWriteValue     (tlbWriteValue),
        .mem               (memIf),
        .csrSatp           (csrSatp),
        .invalidate        (invalidate)
    );

    assign memIf.memGrant     = memIf.memReq & grantEn;
    assign memIf.memRespValid = acc_q | lateResp;
    assign memIf.memReadValue = rdData;

    // zero-wait memory: grant in the request cycle, respond next
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            acc_q  <= 1'b0;
            rdData <= 32'h0;
        end else begin
            acc_q <= memIf.memReq && memIf.memGrant;
            if (memIf.memReq && memIf.memGrant) begin
                if (memIf.memWrite)
                    memArr[memIf.memAddr] = memIf.memWriteValue;
                else if (memArr.exists(memIf.memAddr))
                    rdData <= memArr[memIf.memAddr];
                else
                    rdData <= 32'h0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic paddr_t l1a(input logic [19:0] key);
        return {ROOT, key[19:10], 2'b00};
    endfunction

    function automatic paddr_t l0a(input logic [31:0] ptr,
                                   input logic [19:0] key);
        return {ptr[31:10], key[9:0], 2'b00};
    endfunction

    function automatic TlbEntry leafE(input logic [31:0] pte,
                                      input logic [19:0] key,
                                      input logic sup);
        TlbEntry e;
        e.valid = 1'b1;
        e.fault = 1'b0;
        e.flags = pte[7:0];
        e.pageNumber = sup ? {pte[31:20], key[9:0]} : pte[31:10];
        return e;
    endfunction

    function automatic TlbEntry faultE();
        TlbEntry e;
        e = '0;
        e.valid = 1'b1;
        e.fault = 1'b1;
        return e;
    endfunction

    task automatic pushAcc(input logic wr, input paddr_t a,
                           input logic [31:0] d);
        accQ.push_back('{wr, a, d});
    endtask

    task automatic pushFill(input logic we, input logic [19:0] key,
                            input TlbEntry v);
        fillQ.push_back('{we, key, v});
    endtask

    task automatic walk(input logic [19:0] key, input logic [1:0] at,
                        output int cyc);
        bit got;
        got = 1'b0;
        @(negedge clk);
        requestEnable     = 1'b1;
        requestKey        = key;
        requestAccessType = at;
        cyc = 1;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            requestEnable = 1'b0;
            cyc++;
            if (done) got = 1'b1;
        end
        if (!got) chk("walk_done", 0, 1);
    endtask

    always @(negedge clk) begin
        acc_t  ea;
        fill_t ef;
        if (rstN) begin
            if (memIf.memReq) reqCycles++;
            if (memIf.memReq && memIf.memGrant) begin
                if (accQ.size() == 0) begin
                    chk("mem_extra", 1, 0);
                end else begin
                    ea = accQ.pop_front();
                    chk("mem_wr", memIf.memWrite, ea.wr);
                    chk("mem_addr", memIf.memAddr, ea.addr);
                    if (ea.wr)
                        chk("mem_wdata", memIf.memWriteValue, ea.data);
                end
            end
            if (done) begin
                if (fillQ.size() == 0) begin
                    chk("done_extra", 1, 0);
                end else begin
                    ef = fillQ.pop_front();
                    chk("tlb_we", tlbWriteEnable, ef.we);
                    chk("tlb_key", tlbWriteKey, ef.key);
                    if (ef.we) chk("tlb_val", tlbWriteValue, ef.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0;
        requestEnable = 1'b0;
        requestKey = '0;
        requestAccessType = '0;
        csrSatp = 32'h8008_0000;
        invalidate = 1'b0;
        grantEn = 1'b1;
        lateResp = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", tlbWriteEnable, 0);
        chk("rst_req", memIf.memReq, 0);
        chk("rst_wr", memIf.memWrite, 0);
        chk("rst_addr", memIf.memAddr, 0);
        chk("rst_key", tlbWriteKey, 0);
        rstN = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // two-level walk to a 4 KiB leaf
        k = 20'h00401;
        memArr.delete();
        memArr[l1a(k)] = 32'h2000_0401;
        memArr[l0a(32'h2000_0401, k)] = 32'h0001_00CF;
        pushAcc(0, l1a(k), 0);
        pushAcc(0, l0a(32'h2000_0401, k), 0);
        pushFill(1, k, leafE(32'h0001_00CF, k, 0));
        walk(k, AT_LOAD, lat);
        chk("latency", lat, 6);

        // aligned superpage
        memArr.delete();
        memArr[l1a(k)] = 32'h0040_00CF;
        pushAcc(0, l1a(k), 0);
        pushFill(1, k, leafE(32'h0040_00CF, k, 1));
        walk(k, AT_LOAD, lat);

        // misaligned superpage
        memArr[l1a(k)] = 32'h0040_04CF;
        pushAcc(0, l1a(k), 0);
        pushFill(1, k, faultE());
        walk(k, AT_LOAD, lat);

        // store to clean leaf
        k = 20'h00803;
        memArr.delete();
        memArr[l1a(k)] = 32'h2000_0401;
        memArr[l0a(32'h2000_0401, k)] = 32'h0001_004F;
        pushAcc(0, l1a(k), 0);
        pushAcc(0, l0a(32'h2000_0401, k), 0);
`ifdef PTW_HW_AD_UPDATE_EN
        pushAcc(1, l0a(32'h2000_0401, k), 32'h0001_00CF);
        pushFill(1, k, leafE(32'h0001_00CF, k, 0));
        walk(k, AT_STORE, lat);
        chk("ad_mem", memArr[l0a(32'h2000_0401, k)], 32'h0001_00CF);
`else
        pushFill(1, k, faultE());
        walk(k, AT_STORE, lat);
        chk("no_ad_mem", memArr[l0a(32'h2000_0401, k)], 32'h0001_004F);
`endif

        // invalid root PTE
        memArr.delete();
        memArr[l1a(k)] = 32'h0000_0000;
        pushAcc(0, l1a(k), 0);
        pushFill(1, k, faultE());
        walk(k, AT_LOAD, lat);

        // grant never comes
        grantEn = 1'b0;
        pushFill(1, k, faultE());
        reqCycles = 0;
        walk(k, AT_LOAD, lat);
        chk("to_req_cycles", reqCycles, TO);
        grantEn = 1'b1;
        @(negedge clk);
        lateResp = 1'b1;
        @(negedge clk);
        lateResp = 1'b0;
        chk("late_busy", busy, 0);
        @(negedge clk);
        chk("late_idle", busy, 0);

        // invalidate while waiting on the leaf read
        k = 20'h00401;
        memArr.delete();
        memArr[l1a(k)] = 32'h2000_0401;
        memArr[l0a(32'h2000_0401, k)] = 32'h0001_00CF;
        pushAcc(0, l1a(k), 0);
        pushAcc(0, l0a(32'h2000_0401, k), 0);
        pushFill(0, k, leafE(32'h0001_00CF, k, 0));
        fork
            walk(k, AT_LOAD, lat);
            begin
                int g;
                g = 0;
                for (int i = 0; i < 40 && g < 2; i++) begin
                    @(negedge clk);
                    if (memIf.memReq && memIf.memGrant) g++;
                end
                if (g < 2) begin
                    chk("inv_sync", g, 2);
                end else begin
                    @(posedge clk);
                    #1 invalidate = 1'b1;
                    @(posedge clk);
                    #1 invalidate = 1'b0;
                end
            end
        join

        // drop flag must not linger into the next walk
        pushAcc(0, l1a(k), 0);
        pushAcc(0, l0a(32'h2000_0401, k), 0);
        pushFill(1, k, leafE(32'h0001_00CF, k, 0));
        walk(k, AT_LOAD, lat);

        // reset mid-walk
        pushAcc(0, l1a(k), 0);
        @(negedge clk);
        requestEnable = 1'b1;
        requestKey = k;
        requestAccessType = AT_LOAD;
        @(negedge clk);
        requestEnable = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 1);
        #1 rstN = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req", memIf.memReq, 0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("acc_left", accQ.size(), 0);
        chk("fill_left", fillQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
